// File: rtl/seg_display_pkg.sv
// seg_display_pkg
//   Shared constants for the 7-segment display scanner: active-low glyphs
//   ({g,f,e,d,c,b,a}), page encodings, digit count and an anode helper.
//   No ports; imported by seg_display_scanner and bcd_to_seg7.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    PAGE_A = 2'd0,
    PAGE_B = 2'd1,
    PAGE_C = 2'd2,
    PAGE_D = 2'd3
  } page_t;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_display_scanner_bcd_to_seg7.sv
// bcd_to_seg7
//   Combinational BCD nibble to active-low 7-segment glyph. Values 0-9 give
//   the decimal glyph; 0xA-0xF give a dash.
// Ports
//   nibble  in   4  BCD digit
//   glyph   out  7  {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_DASH;
    case (nibble)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Time-multiplexes one of four 16-bit BCD words onto a 4-digit common-anode
//   7-segment display. The page is advanced by page_next and/or an optional
//   auto-advance timer. The displayed word is latched once per frame so the
//   digits of one scan always come from the same value.
// Parameters
//   REFRESH_DIV  clk cycles each digit stays lit (>= 2)
//   PAGE_HOLD    auto-advance period in clk cycles, 0 disables auto-advance
// Configuration macro
//   SEG_LEADING_ZERO_BLANK_EN  when defined, leading zero digits 3..1 are blank
// Ports
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high
//   digits_A   in   16  page 0 word, [15:12] = most significant digit
//   digits_B   in   16  page 1 word
//   digits_C   in   16  page 2 word
//   digits_D   in   16  page 3 word
//   page_next  in   1   single-cycle pulse, advance page
//   seg        out  7   {g,f,e,d,c,b,a}, active-low
//   an         out  4   anodes, active-low, an[0] = least significant digit
//   dp         out  1   decimal point, active-low, marks the current page
//   page_id    out  2   current page
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int PAGE_HOLD   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_A,
  input  logic [15:0] digits_B,
  input  logic [15:0] digits_C,
  input  logic [15:0] digits_D,
  input  logic        page_next,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  page_id
);

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0]          refresh_reg, refresh_next;
  logic [1:0]             idx_reg, idx_next;
  logic                   started_reg, started_next;
  logic [15:0]            snapshot_reg, snapshot_next;
  logic [15:0]            selected;
  logic [1:0]             page_reg, page_id_next;
  logic                   tc, frame_latch, hold_expire, advance;
  logic [3:0]             nibble;
  logic [6:0]             glyph;
  logic [NUM_DIGITS-1:0]  lead_zero;
  logic [3:0]             an_next;
  logic [6:0]             seg_next;
  logic                   dp_next;

  // ---------------------------------------------------------------------------
  // Refresh / digit scan / frame latch
  // ---------------------------------------------------------------------------
  assign tc = (refresh_reg == REFRESH_LAST);

  // The first tc after reset lights digit 0 rather than stepping past it, and
  // it also loads the first frame.
  assign frame_latch = tc && (!started_reg || idx_reg == 2'd3);

  always_comb begin
    case (page_reg)
      PAGE_A:  selected = digits_A;
      PAGE_B:  selected = digits_B;
      PAGE_C:  selected = digits_C;
      default: selected = digits_D;
    endcase
  end

  always_comb begin
    refresh_next  = tc ? '0 : refresh_reg + 1'b1;
    started_next  = started_reg | tc;
    idx_next      = (tc && started_reg) ? idx_reg + 2'd1 : idx_reg;
    snapshot_next = frame_latch ? selected : snapshot_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_reg  <= '0;
      idx_reg      <= 2'd0;
      started_reg  <= 1'b0;
      snapshot_reg <= 16'h0000;
    end else begin
      refresh_reg  <= refresh_next;
      idx_reg      <= idx_next;
      started_reg  <= started_next;
      snapshot_reg <= snapshot_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Page selection and auto-advance timer
  // ---------------------------------------------------------------------------
  generate
    if (PAGE_HOLD > 0) begin : g_hold
      localparam int HW = (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;
      localparam logic [HW-1:0] HOLD_LAST = HW'(PAGE_HOLD - 1);
      logic [HW-1:0] hold_reg;

      assign hold_expire = (hold_reg == HOLD_LAST);

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          hold_reg <= '0;
        else if (page_next || hold_expire)
          hold_reg <= '0;
        else
          hold_reg <= hold_reg + 1'b1;
      end
    end else begin : g_no_hold
      assign hold_expire = 1'b0;
    end
  endgenerate

  // A button pulse coinciding with timer expiry is a single advance.
  assign advance      = page_next | hold_expire;
  assign page_id_next = page_reg + {1'b0, advance};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      page_reg <= PAGE_A;
    else
      page_reg <= page_id_next;
  end

  assign page_id = page_reg;

  // ---------------------------------------------------------------------------
  // Digit decode. Outputs are registered from next-state values so the anode,
  // glyph and dp all follow the new index on the cycle right after tc.
  // ---------------------------------------------------------------------------
  assign nibble = snapshot_next[{idx_next, 2'b00} +: 4];

  bcd_to_seg7 u_bcd_to_seg7 (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // lead_zero[gi]: digit gi and every higher digit are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead_zero
    assign lead_zero[gi] = ~|snapshot_next[4*NUM_DIGITS-1 : 4*gi];
  end

  always_comb begin
    an_next  = 4'b1111;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (started_next) begin
      an_next  = anode_for(idx_next);
      seg_next = glyph;
      if (BLANK_EN && idx_next != 2'd0 && lead_zero[idx_next])
        seg_next = SEG_BLANK;
      dp_next  = (idx_next == page_id_next) ? 1'b0 : 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
